rv_imem: RTL

- Instruction-memory responder on the fetch interface.
- Accepts a PC from the fetch stage in Q100H and returns the addressed 32-bit instruction in Q101H.
- Drives the ready that stalls the PC register.
- Adds configurable wait states, downstream backpressure, misalignment flagging, and a program-load write port used by testbenches and boot.

---
 rtl/rv_imem.sv | 127 ++++++++++++
 1 files changed

// File: rtl/rv_imem.sv
// Instruction-memory responder for the fetch stage: accepts a PC in Q100H and
// returns the addressed word in Q101H, with optional wait states and backpressure.
module rv_imem #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013,
  localparam int unsigned ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_Q100H,
  input  logic [31:0]       pc_Q100H,
  output logic              req_ready_Q100H,
  output logic              rsp_valid_Q101H,
  output logic [31:0]       instr_Q101H,
  output logic              misaligned_Q101H,
  input  logic              rsp_ready_Q101H,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

  logic [31:0]       r_mem [MEM_DEPTH];
  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_mis;
  logic              r_rsp_valid;
  logic [31:0]       r_instr;
  logic              r_rsp_mis;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_done;
  logic [ADDR_W-1:0] w_pc_idx;
  logic              w_pc_mis;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_mis;
  logic [31:0]       w_rd_word;
  logic              w_unused;

  // PC bits above the word index only alias; they are intentionally dropped.
  assign w_unused = &{1'b0, pc_Q100H[31:ADDR_W+2]};

  assign w_pc_idx    = pc_Q100H[ADDR_W+1:2];
  assign w_pc_mis    = (pc_Q100H[1:0] != 2'b00);
  assign w_rsp_done  = r_rsp_valid & rsp_ready_Q101H;
  assign w_req_ready = (r_state == S_IDLE) & ~load_en & (~r_rsp_valid | rsp_ready_Q101H);
  assign w_accept    = req_valid_Q100H & w_req_ready;

  assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_pc_idx;
  assign w_rd_mis = (r_state == S_WAIT) ? r_mis : w_pc_mis;
  // A load landing on the WAIT-exit edge for the same word is forwarded.
  assign w_rd_word = (load_en && (load_addr == w_rd_idx)) ? load_data : r_mem[w_rd_idx];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_capture = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = WS_INIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_capture    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_idx       <= '0;
      r_mis       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_rsp_mis   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_idx <= w_pc_idx;
        r_mis <= w_pc_mis;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_instr     <= w_rd_mis ? NOP_INSTR : w_rd_word;
        r_rsp_mis   <= w_rd_mis;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Program contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (load_en) begin
      r_mem[load_addr] <= load_data;
    end
  end

  assign req_ready_Q100H  = w_req_ready;
  assign rsp_valid_Q101H  = r_rsp_valid;
  assign instr_Q101H      = r_instr;
  assign misaligned_Q101H = r_rsp_mis;

endmodule
